golden_nonce_fifo: RTL

GOLDEN_NONCE_FIFO -- requirements
Module: golden_nonce_fifo

---
 rtl/golden_nonce_fifo_pkg.sv | 16 +
 rtl/golden_nonce_fifo_nonce_ram.sv | 33 +++
 rtl/golden_nonce_fifo.sv | 124 ++++++++++++
 3 files changed

// File: rtl/golden_nonce_fifo_pkg.sv
// Shared nonce definitions used by the golden-nonce FIFO and the miner cores.
// Holds the nonce width, the miner idle value and the nonce adjust helper.
package golden_nonce_fifo_pkg;

   localparam int NONCE_W = 32;

   typedef logic [NONCE_W-1:0] nonce_t;

   // A miner parks its golden-nonce register at this value when it has no result.
   localparam nonce_t IDLE_NONCE = '0;

   function automatic nonce_t nonce_adjust(input nonce_t raw, input nonce_t adj);
      return raw + adj;
   endfunction

endpackage

// File: rtl/golden_nonce_fifo_nonce_ram.sv
// DEPTH x NONCE_W storage for the golden-nonce FIFO: one synchronous write port
// and one registered read port, written so it maps onto block RAM.
module nonce_ram
   import golden_nonce_fifo_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  nonce_t                   wr_data_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output nonce_t                   rd_data_o
);

   nonce_t mem_q [DEPTH];
   nonce_t rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read-during-write to the same address returns the old word; the FIFO
   // control bypasses that case itself.
   always_ff @(posedge clk) begin
      rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/golden_nonce_fifo.sv
// Captures each new nonzero golden nonce from a miner core into a small
// first-word-fall-through FIFO with a sticky overflow flag.
module golden_nonce_fifo
   import golden_nonce_fifo_pkg::*;
#(
   parameter int     DEPTH     = 8,
   parameter nonce_t NONCE_ADJ = 32'd0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  nonce_t                 golden_nonce,
   input  logic                   rd_en,
   output nonce_t                 rd_data,
   output logic                   rd_valid,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   nonce_t          last_q, last_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            bypass_q, bypass_d;
   nonce_t          bypass_data_q, bypass_data_d;

   logic            pop;
   logic            full;
   logic            changed;
   logic            capture;
   logic            push;
   logic            drop;
   logic            ram_wr_en;
   nonce_t          push_data;
   nonce_t          ram_rd_data;

   assign pop       = rd_en && (count_q != '0);
   assign full      = (count_q == CW'(DEPTH));
   assign changed   = (golden_nonce != last_q);
   assign capture   = changed && (golden_nonce != IDLE_NONCE);
   assign push      = capture && (!full || pop);
   assign drop      = capture && full && !pop;
   assign push_data = nonce_adjust(golden_nonce, NONCE_ADJ);

   always_comb begin
      last_d        = last_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      overflow_d    = overflow_q;
      bypass_d      = 1'b0;
      bypass_data_d = bypass_data_q;
      ram_wr_en     = 1'b0;
      if (clear) begin
         last_d     = golden_nonce;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         bypass_d   = 1'b1;
      end else begin
         if (changed) begin
            last_d = golden_nonce;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push) begin
            ram_wr_en = reset;
            wr_ptr_d  = wr_ptr_q + AW'(1);
         end
         if (drop) begin
            overflow_d = 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
         // The pushed word becomes the head; the RAM cannot show it yet.
         if (push && ((count_q - CW'(pop)) == '0)) begin
            bypass_d      = 1'b1;
            bypass_data_d = push_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_q        <= IDLE_NONCE;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         bypass_q      <= 1'b1;
         bypass_data_q <= '0;
      end else begin
         last_q        <= last_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         bypass_q      <= bypass_d;
         bypass_data_q <= bypass_data_d;
      end
   end

   nonce_ram #(
      .DEPTH(DEPTH)
   ) u_nonce_ram (
      .clk       (clk),
      .wr_en_i   (ram_wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (push_data),
      .rd_addr_i (rd_ptr_d),
      .rd_data_o (ram_rd_data)
   );

   assign rd_data  = bypass_q ? bypass_data_q : ram_rd_data;
   assign rd_valid = (count_q != '0);
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule
